// File: rtl/data_memory_be_pkg.sv
// Shared types and default sizes for the byte-addressable MEM-stage data memory.
package data_memory_be_pkg;

    localparam int PC_BITS     = 32;
    localparam int SIZE_MEMORY = 1024;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_READY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_memory_be_load_store_align.sv
// Combinational lane steering: store byte enables/replicated data, load extraction
// with sign/zero extension, and the alignment check.
module load_store_align
    import data_memory_be_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [15:0] shifted;

    always_comb begin
        byte_en    = 4'b0000;
        store_word = '0;
        load_data  = '0;
        misaligned = 1'b0;
        shifted    = 16'(raw_word >> {lane, 3'b000});
        case (size)
            MEM_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = raw_word;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory with sub-word loads/stores, range/alignment flags,
// optional registered read, and a post-reset clear sweep that stalls the pipeline.
module data_memory_be
    import data_memory_be_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = PC_BITS,
    parameter int DEPTH        = SIZE_MEMORY,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic              mem_write_m,
    input  logic              mem_read_m,
    input  logic [1:0]        mem_size_m,
    input  logic              mem_unsigned_m,
    output logic [DATA_W-1:0] read_data_m,
    output logic              read_valid_m,
    output logic              misaligned_m,
    output logic              out_of_range_m,
    output logic              stall_m
);

    localparam int IDX_W = $clog2(DEPTH);

    mem_state_t         state_q, state_d;
    logic [IDX_W-1:0]   clear_cnt_q, clear_cnt_d;

    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  raw_word;
    logic [3:0]         lane_be;
    logic [DATA_W-1:0]  store_word;
    logic [DATA_W-1:0]  ext_data;
    logic               mis_raw;
    logic               oor_raw;
    logic               ready;
    logic               active;
    logic               bad;
    logic               load_hit;
    logic [DATA_W-1:0]  load_word;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         wr_be;
    logic [DATA_W-1:0]  wr_word;

    assign word_idx = addr_m[IDX_W+1:2];
    // DEPTH is a power of two, so any set bit above the index field is out of range.
    assign oor_raw  = |addr_m[ADDR_W-1:IDX_W+2];
    assign ready    = (state_q == MEM_READY);
    assign active   = (mem_read_m | mem_write_m) & ready;
    assign bad      = mis_raw | oor_raw;
    assign load_hit = mem_read_m & ready;
    assign load_word = (load_hit & ~bad) ? ext_data : '0;

    assign misaligned_m   = active & mis_raw;
    assign out_of_range_m = active & oor_raw;
    assign stall_m        = ~ready;

    load_store_align u_align (
        .size        (mem_size_m),
        .lane        (addr_m[1:0]),
        .is_unsigned (mem_unsigned_m),
        .store_data  (write_data_m),
        .raw_word    (raw_word),
        .byte_en     (lane_be),
        .store_word  (store_word),
        .load_data   (ext_data),
        .misaligned  (mis_raw)
    );

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        wr_en       = 1'b0;
        wr_idx      = word_idx;
        wr_be       = lane_be;
        wr_word     = store_word;
        if (state_q == MEM_CLEAR) begin
            wr_en       = ~rst;
            wr_idx      = clear_cnt_q;
            wr_be       = 4'b1111;
            wr_word     = '0;
            clear_cnt_d = clear_cnt_q + 1'b1;
            if (clear_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = MEM_READY;
            end
        end else begin
            wr_en = mem_write_m & ~bad & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MEM_CLEAR;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    // One array per byte lane keeps each lane a plain single-writer RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_word[gi*8 +: 8];
                end
            end
            assign raw_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign read_data_m  = load_word;
            assign read_valid_m = load_hit;
        end else begin : g_reg_read
            logic [DATA_W-1:0] rdata_q, rdata_d;
            logic              rvalid_q, rvalid_d;
            always_comb begin
                rdata_d  = load_hit ? load_word : rdata_q;
                rvalid_d = load_hit;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end
            assign read_data_m  = rdata_q;
            assign read_valid_m = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_be.sv
// Drives a combinational-read and a registered-read instance with the same stimulus.
module tb_data_memory_be;
    import data_memory_be_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        mem_uns;

    logic [31:0] r0_data, r1_data;
    logic        r0_valid, r1_valid, r0_mis, r1_mis, r0_oor, r1_oor, r0_stall, r1_stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    int          n;

    always #5 clk = ~clk;

    data_memory_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .READ_LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .addr_m(addr), .write_data_m(wdata),
        .mem_write_m(mem_write), .mem_read_m(mem_read), .mem_size_m(mem_size),
        .mem_unsigned_m(mem_uns), .read_data_m(r0_data), .read_valid_m(r0_valid),
        .misaligned_m(r0_mis), .out_of_range_m(r0_oor), .stall_m(r0_stall)
    );

    data_memory_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .addr_m(addr), .write_data_m(wdata),
        .mem_write_m(mem_write), .mem_read_m(mem_read), .mem_size_m(mem_size),
        .mem_unsigned_m(mem_uns), .read_data_m(r1_data), .read_valid_m(r1_valid),
        .misaligned_m(r1_mis), .out_of_range_m(r1_oor), .stall_m(r1_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Registered-read instance: every valid pulse must match the oldest queued load.
    always @(negedge clk) begin
        if (r1_valid === 1'b1) begin
            if (exp_q.size() == 0) check("lat1_spurious_valid", {31'b0, r1_valid}, 32'h0);
            else                   check("lat1_data", r1_data, exp_q.pop_front());
        end
    end

    task automatic idle();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_size  = 2'd2;
        mem_uns   = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input logic em, input logic eo);
        addr = a; mem_size = sz; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        $display("STORE addr=0x%02h size=%0d data=0x%08h mis=%0b oor=%0b", a, sz, d, r0_mis, r0_oor);
        check("st_mis_l0", {31'b0, r0_mis}, {31'b0, em});
        check("st_oor_l0", {31'b0, r0_oor}, {31'b0, eo});
        check("st_mis_l1", {31'b0, r1_mis}, {31'b0, em});
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input logic [31:0] exp, input logic em, input logic eo);
        addr = a; mem_size = sz; mem_uns = uns; mem_read = 1'b1; mem_write = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        $display("LOAD  addr=0x%02h size=%0d uns=%0b data=0x%08h exp=0x%08h", a, sz, uns, r0_data, exp);
        check("ld_data_l0", r0_data, exp);
        check("ld_valid_l0", {31'b0, r0_valid}, 32'h1);
        check("ld_mis_l0", {31'b0, r0_mis}, {31'b0, em});
        check("ld_oor_l0", {31'b0, r0_oor}, {31'b0, eo});
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        addr = a; mem_size = 2'd2; wdata = d; mem_read = 1'b1; mem_write = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        $display("RW    addr=0x%02h wdata=0x%08h rdata=0x%08h exp=0x%08h", a, d, r0_data, exp);
        check("rw_data_l0", r0_data, exp);
        @(posedge clk); #1;
        idle();
    endtask

    // Counts stalled cycles; optionally fires a store/load and a flaggable access mid-clear.
    task automatic clear_run(input bit with_req, output int cnt);
        cnt = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (with_req && cyc == 3) begin
                addr = 32'h0; wdata = 32'h7; mem_size = 2'd2; mem_write = 1'b1; mem_read = 1'b1;
            end else if (with_req && cyc == 4) begin
                addr = 32'h41; wdata = 32'h7; mem_size = 2'd1; mem_write = 1'b1; mem_read = 1'b1;
            end
            @(negedge clk);
            if (r0_stall !== 1'b1) break;
            if (with_req && (cyc == 3 || cyc == 4)) begin
                $display("CLEAR-REQ cyc=%0d addr=0x%02h valid=%0b mis=%0b oor=%0b", cyc, addr, r0_valid, r0_mis, r0_oor);
                check("clr_valid_l0", {31'b0, r0_valid}, 32'h0);
                check("clr_mis_l0", {31'b0, r0_mis}, 32'h0);
                check("clr_oor_l0", {31'b0, r0_oor}, 32'h0);
                check("clr_data_l0", r0_data, 32'h0);
                check("clr_stall_l1", {31'b0, r1_stall}, 32'h1);
            end
            cnt++;
            @(posedge clk); #1;
            idle();
        end
        check("clr_end_stall_l1", {31'b0, r1_stall}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        $display("RESET stall=%0b valid=%0b data=0x%08h", r0_stall, r0_valid, r0_data);
        check("rst_data_l0", r0_data, 32'h0);
        check("rst_valid_l0", {31'b0, r0_valid}, 32'h0);
        check("rst_mis_l0", {31'b0, r0_mis}, 32'h0);
        check("rst_oor_l0", {31'b0, r0_oor}, 32'h0);
        check("rst_stall_l0", {31'b0, r0_stall}, 32'h1);
        check("rst_data_l1", r1_data, 32'h0);
        check("rst_valid_l1", {31'b0, r1_valid}, 32'h0);
        check("rst_stall_l1", {31'b0, r1_stall}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Initial clear with requests injected during the sweep.
        clear_run(1'b1, n);
        $display("CLEAR stall_cycles=%0d", n);
        check("stall_cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) do_load(32'(i * 4), 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) do_store(32'(i * 4), 2'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Reset mid-clear must restart the sweep.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_run(1'b0, n);
        $display("CLEAR-RESTART stall_cycles=%0d", n);
        check("stall_cycles_restart", n, 32'd16);
        for (int i = 0; i < 16; i++) do_load(32'(i * 4), 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);

        // Sub-word stores and extending loads.
        do_store(32'h8, 2'd2, 32'h1122_3344, 1'b0, 1'b0);
        do_store(32'h9, 2'd0, 32'h0000_00AA, 1'b0, 1'b0);
        do_store(32'hA, 2'd1, 32'h0000_BEEF, 1'b0, 1'b0);
        do_load(32'h8, 2'd2, 1'b0, 32'hBEEF_AA44, 1'b0, 1'b0);
        do_load(32'h9, 2'd0, 1'b0, 32'hFFFF_FFAA, 1'b0, 1'b0);
        do_load(32'h9, 2'd0, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
        do_load(32'hA, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0, 1'b0);
        do_load(32'hA, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
        do_load(32'h8, 2'd0, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
        do_load(32'hB, 2'd0, 1'b1, 32'h0000_00BE, 1'b0, 1'b0);

        // Misaligned and out-of-range accesses.
        do_store(32'h4, 2'd2, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_store(32'h6, 2'd2, 32'h1234_5678, 1'b1, 1'b0);
        do_load(32'h4, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_store(32'h41, 2'd1, 32'h0000_5555, 1'b1, 1'b1);
        do_load(32'h40, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        do_load(32'h5, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_store(32'h4, 2'd3, 32'h0, 1'b1, 1'b0);
        do_load(32'h4, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Read-during-write is read-first.
        do_store(32'hC, 2'd2, 32'h5, 1'b0, 1'b0);
        do_rw(32'hC, 32'h9, 32'h5);
        do_load(32'hC, 2'd2, 1'b0, 32'h9, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("lat1_pending", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Parametrised, byte-addressable data memory for the MEM stage of the pipelined MIPS core, successor to the word-only data memory. Adds:
- byte/half/word loads and stores with sign or zero extension
- alignment and range checking
- optional registered read port
- a sequential clear engine after reset that stalls the pipeline until memory is zeroed

Parameters:
DATA_W, 32, data word width in bits; only 32 is supported.
ADDR_W, 32, byte-address width; PC_BITS from CPU_def.
DEPTH, 1024, number of DATA_W words; must be a power of two and at least 2.
READ_LATENCY, 0, 0 = combinational read, 1 = registered read; no other values are legal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
addr_m  in  ADDR_W  byte address (ALU result)
write_data_m  in  DATA_W  store data, right-aligned
mem_write_m  in  1  store request
mem_read_m  in  1  load request
mem_size_m  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal
mem_unsigned_m  in  1  1 = zero-extend loads, 0 = sign-extend
read_data_m  out  DATA_W  extended load data
read_valid_m  out  1  load data valid
misaligned_m  out  1  current access is misaligned
out_of_range_m  out  1  current access address is at or above DEPTH*4
stall_m  out  1  memory busy clearing; pipeline must hold

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset action: rst sampled high at a rising edge sets state CLEAR and clear_cnt = 0.
- Reset outputs: read_data_m = 0, read_valid_m = 0, misaligned_m = 0, out_of_range_m = 0, stall_m = 1.
- rst asserted mid-clear restarts clear_cnt at 0.
- FSM has two states, CLEAR and READY.
  - CLEAR: each edge with rst low writes 0 to word[clear_cnt] and increments clear_cnt.
  - The edge that clears word DEPTH-1 moves the FSM to READY.
  - stall_m = (state == CLEAR); it is high for exactly DEPTH cycles after rst deasserts.
  - All requests in CLEAR are ignored: no writes, read_valid_m = 0, flags = 0.
- Address decode:
  - word index = addr_m[$clog2(DEPTH)+1 : 2]
  - byte lane = addr_m[1:0]
  - out_of_range when addr_m >= DEPTH*4
- Alignment rules:
  - half is misaligned if addr_m[0] = 1
  - word is misaligned if addr_m[1:0] != 0
  - byte is never misaligned
  - mem_size_m = 3 is treated as misaligned.
- Flags are combinational, qualified by (mem_read_m | mem_write_m) and state READY.
- Stores, in READY with mem_write_m high, flags clear, at the rising edge:
  - byte store writes lane addr_m[1:0] with write_data_m[7:0]
  - half store writes lanes {addr_m[1],0} and {addr_m[1],1} with write_data_m[15:0] (little-endian)
  - word store writes the whole word
  - other lanes are unchanged.
- A flagged store is suppressed; memory is unchanged.
- Loads extract the lane(s) selected by addr_m and extend to DATA_W per mem_unsigned_m. A flagged load returns 0.
- Load latency:
  - READ_LATENCY 0: read_data_m is combinational from current inputs; read_valid_m = mem_read_m & READY.
  - READ_LATENCY 1: data and valid are registered and appear the cycle after the request; read_valid_m is a single-cycle pulse per request cycle.
- Read-during-write to the same word returns the pre-write contents (read-first) in both modes.
- With no load, read_data_m holds 0 in mode 0 and holds its last value in mode 1.
- Simultaneous mem_read_m and mem_write_m are legal: the read is read-first and the write commits at the edge.

Decomposition:
- CPU_def package gains:
  - typedef enum logic [1:0] mem_size_t {MEM_BYTE, MEM_HALF, MEM_WORD}
  - typedef enum logic mem_state_t {MEM_CLEAR, MEM_READY}
- PC_BITS and SIZE_MEMORY remain the defaults for ADDR_W and DEPTH.
- One natural sub-module, load_store_align:
  - combinational
  - produces 4-bit byte enables and the lane-shifted store word from size and lane
  - produces the extended load result from the raw word
  - produces the misaligned flag.

Test Plan (DEPTH = 16):
1. Reset-clear: rst high 1 cycle, then low. stall_m = 1 for exactly 16 cycles, then 0. A word read of every address returns 0.
2. Reset mid-clear: assert rst at clear cycle 7. clear_cnt restarts; stall_m stays high for 16 further cycles after rst falls.
3. Sub-word stores: sw 0x11223344 @0x8, then sb 0xAA @0x9, then sh 0xBEEF @0xA. lw @0x8 = 0xBEEFAA44. lb @0x9 = 0xFFFFFFAA, lbu @0x9 = 0x000000AA, lh @0xA = 0xFFFFBEEF.
4. Misaligned and range: sw @0x6 gives misaligned_m = 1 and word 1 unchanged. sh @0x41 gives misaligned_m = 1. lw @0x40 gives out_of_range_m = 1 and read_data_m = 0.
5. Read-during-write: word 3 = 0x5; issue read and write of 0x9 @0xC in the same cycle. Read returns 0x5 (next cycle in READ_LATENCY = 1 with read_valid_m pulse); a following read returns 0x9.
6. Requests during CLEAR: sw 0x7 @0x0 while stall_m = 1. After READY, lw @0x0 = 0 and read_valid_m was never asserted during CLEAR.
